// File: rtl/rv32_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand magnitudes.
// Optional build macro RV32_MULDIV_EARLY_OUT_EN lets trivial cases skip the iteration phase.
module rv32_muldiv_unit #(
    parameter int ITER_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    localparam int N = 32 / ITER_PER_CLK;
    localparam logic [4:0] CNT_INIT = 5'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [2:0]  op_r;
    logic [31:0] b_mag_r;
    logic [31:0] dividend_r;
    logic        neg_res_r, neg_rem_r, dz_r, ovf_r;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r, acc_step_s;
    logic [4:0]  rd_r;
    logic        done_r;
    logic [31:0] result_r;
    logic [4:0]  rd_out_r;
    logic        busy_s;
    logic        accept_s, early_s;
    logic        sign_a_s, sign_b_s, dz_s, ovf_s;
    logic [31:0] a_mag_s, b_mag_s, res_calc_s, res_early_s;

    // One radix-2 step; acc holds {hi,lo} for multiply and {remainder,quotient} for divide.
    function automatic logic [63:0] iter_step(input logic [63:0] acc, input logic [31:0] b,
                                              input logic is_div);
        logic [32:0] part;
        logic [63:0] res;
        if (is_div) begin
            part = {acc[63:32], acc[31]};
            if (part >= {1'b0, b}) begin
                part = part - {1'b0, b};
                res  = {part[31:0], acc[30:0], 1'b1};
            end else begin
                res  = {part[31:0], acc[30:0], 1'b0};
            end
        end else begin
            part = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b} : 33'd0);
            res  = {part, acc[31:1]};
        end
        return res;
    endfunction

    // Sign correction, special-case override and result selection.
    function automatic logic [31:0] finalize(input logic [63:0] acc, input logic [2:0] o,
                                             input logic neg_res, input logic neg_rem,
                                             input logic dz, input logic ovf,
                                             input logic [31:0] dividend);
        logic [63:0] prod;
        logic [31:0] quo, rem, res;
        prod = neg_res ? (64'd0 - acc) : acc;
        quo  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
        rem  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
        if (dz) begin
            quo = 32'hFFFF_FFFF;
            rem = dividend;
        end else if (ovf) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end
        case (o)
            3'b000:                 res = prod[31:0];
            3'b001, 3'b010, 3'b011: res = prod[63:32];
            3'b100, 3'b101:         res = quo;
            default:                res = rem;
        endcase
        return res;
    endfunction

    // MULHSU treats only rs1 as signed; DIV/REM treat both as signed.
    assign sign_a_s = rs1[31] & ((op == 3'b001) | (op == 3'b010) | (op[2] & ~op[0]));
    assign sign_b_s = rs2[31] & ((op == 3'b001) | (op[2] & ~op[0]));
    assign a_mag_s  = sign_a_s ? (32'd0 - rs1) : rs1;
    assign b_mag_s  = sign_b_s ? (32'd0 - rs2) : rs2;
    assign dz_s     = op[2] & (rs2 == 32'd0);
    assign ovf_s    = op[2] & ~op[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
    assign accept_s = start & ~flush;

`ifdef RV32_MULDIV_EARLY_OUT_EN
    assign early_s = dz_s | ovf_s | (~op[2] & ((rs1 == 32'd0) | (rs2 == 32'd0)));
`else
    assign early_s = 1'b0;
`endif

    assign res_early_s = finalize(64'd0, op, 1'b0, 1'b0, dz_s, ovf_s, rs1);
    assign res_calc_s  = finalize(acc_step_s, op_r, neg_res_r, neg_rem_r, dz_r, ovf_r, dividend_r);

    // Next-state, hold request and ITER_PER_CLK chained iteration steps.
    always_comb begin
        state_nxt_s = state_r;
        busy_s      = 1'b0;
        acc_step_s  = acc_r;
        for (int i = 0; i < ITER_PER_CLK; i++) begin
            acc_step_s = iter_step(acc_step_s, b_mag_r, op_r[2]);
        end
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    busy_s      = 1'b1;
                    state_nxt_s = early_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    busy_s      = 1'b1;
                    state_nxt_s = (cnt_r == 5'd0) ? DONE : CALC;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    assign busy   = rst_n & busy_s;
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_out_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand latching, iteration datapath and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= 3'd0;
            b_mag_r    <= 32'd0;
            dividend_r <= 32'd0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
            cnt_r      <= 5'd0;
            acc_r      <= 64'd0;
            rd_r       <= 5'd0;
            result_r   <= 32'd0;
            rd_out_r   <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r       <= op;
                        b_mag_r    <= b_mag_s;
                        dividend_r <= rs1;
                        neg_res_r  <= sign_a_s ^ sign_b_s;
                        neg_rem_r  <= sign_a_s;
                        dz_r       <= dz_s;
                        ovf_r      <= ovf_s;
                        cnt_r      <= CNT_INIT;
                        acc_r      <= {32'd0, a_mag_s};
                        rd_r       <= rd_in;
                        if (early_s) begin
                            result_r <= res_early_s;
                            rd_out_r <= rd_in;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r - 5'd1;
                    if (!flush && cnt_r == 5'd0) begin
                        result_r <= res_calc_s;
                        rd_out_r <= rd_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_muldiv_unit.sv
// Scoreboard testbench for rv32_muldiv_unit: driver pushes expected responses, a monitor checks done pulses.
module tb_rv32_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int failures = 0;
    logic [31:0] cyc = 32'd0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic [31:0] cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;
    vec_t vecs[$];

    rv32_muldiv_unit #(.ITER_PER_CLK(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .op(op),
        .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got result %h with empty scoreboard", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit special);
        int lat;
        exp_t e;
        lat = 33;
`ifdef RV32_MULDIV_EARLY_OUT_EN
        if (special) lat = 1;
`else
        if (special) lat = 33;
`endif
        @(negedge clk);
        op = o; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
        e.res = exp; e.rd = rd; e.cyc = cyc + 32'(lat);
        sb.push_back(e);
        #1 check("busy_accept", {31'd0, busy}, 32'd1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            #1 check("busy_hold", {31'd0, busy}, (k < lat) ? 32'd1 : 32'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,        1'b0});
        vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,         1'b0});
        vecs.push_back('{3'b100, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6,         1'b0});
        vecs.push_back('{3'b110, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0});
        vecs.push_back('{3'b100, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{3'b110, 32'd5,          32'd0,          32'd5,         1'b1});
        vecs.push_back('{3'b111, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 1'b1});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1});
        vecs.push_back('{3'b000, 32'd0,          32'd12345,      32'd0,         1'b1});

        // Reset state, with start high to confirm busy is held low.
        start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, vecs[i].special);
        end

        // Flush a DIV in its tenth busy cycle; the next op starts two cycles later.
        @(negedge clk);
        op = 3'b100; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd30; start = 1'b1;
        #1 check("flush_busy_accept", {31'd0, busy}, 32'd1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1 check("flush_busy_drop", {31'd0, busy}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1 check("flush_busy_idle", {31'd0, busy}, 32'd0);
        run_op(3'b101, 32'd100, 32'd7, 5'd29, 32'd14, 1'b0);

        // Reset in the middle of a MUL.
        @(negedge clk);
        op = 3'b000; rs1 = 32'd3; rs2 = 32'd7; rd_in = 5'd17; start = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd_out", {27'd0, rd_out}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        run_op(3'b000, 32'd3, 32'd5, 5'd18, 32'd15, 1'b0);

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
